// File: rtl/uart_fifo_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctl_if
// Purpose  : Host byte streams, divisor request and UART register port of
//            the UART FIFO controller.
// Revision : 1.0
// ============================================================================
interface uart_fifo_ctl_if;
    // host transmit stream
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    // host receive stream
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    // divisor reprogramming
    logic        cfg_valid;
    logic [11:0] cfg_div;
    logic        cfg_ready;
    // status
    logic        overrun;
    logic        ovr_clr;
    logic        irq;
    // UART register port
    logic [3:0]  u_addr;
    logic [7:0]  u_wdata;
    logic        u_write;
    logic        u_read;
    logic [7:0]  u_rdata;

    modport master (
        input  tx_valid, tx_data, rx_ready, cfg_valid, cfg_div, ovr_clr, u_rdata,
        output tx_ready, rx_valid, rx_data, cfg_ready, overrun, irq,
               u_addr, u_wdata, u_write, u_read
    );

    modport slave (
        output tx_valid, tx_data, rx_ready, cfg_valid, cfg_div, ovr_clr, u_rdata,
        input  tx_ready, rx_valid, rx_data, cfg_ready, overrun, irq,
               u_addr, u_wdata, u_write, u_read
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctl
// Purpose  : TX/RX byte FIFOs plus a polling sequencer that owns the UART
//            register port (status poll, RX drain, TX feed, divisor writes).
// Revision : 1.0
// ============================================================================
module uart_fifo_ctl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  wire logic       clk,
    input  wire logic       reset,
    uart_fifo_ctl_if.master bus
);

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    localparam logic [2:0] S_POLL = 3'd0;
    localparam logic [2:0] S_RXRD = 3'd1;
    localparam logic [2:0] S_TXWR = 3'd2;
    localparam logic [2:0] S_DIVL = 3'd3;
    localparam logic [2:0] S_DIVH = 3'd4;

    localparam logic [3:0] C_A_RX = 4'd0;
    localparam logic [3:0] C_A_TX = 4'd1;
    localparam logic [3:0] C_A_ST = 4'd2;
    localparam logic [3:0] C_A_DL = 4'd4;
    localparam logic [3:0] C_A_DH = 4'd5;

    logic [2:0]    state_q, state_d;

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW:0]   tx_count_q, tx_count_d;

    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [AW:0]   rx_count_q, rx_count_d;

    logic          tx_busy_q, tx_busy_d;
    logic          overrun_q, overrun_d;
    logic [11:0]   div_q, div_d;

    logic [1:0]    st;
    logic          tx_ok;
    logic          tx_empty;
    logic          tx_full;
    logic          rx_empty;
    logic          rx_full;
    logic          tx_push;
    logic          tx_pop;
    logic          rx_push;
    logic          rx_push_ok;
    logic          rx_pop;
    logic          rx_drop;
    logic          cfg_take;

    // Status bits as seen while S_POLL presents address 2: [1]=rint, [0]=xint.
    assign st       = bus.u_rdata[1:0];
    assign tx_ok    = ~tx_busy_q | st[0];

    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == C_FULL);
    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == C_FULL);

    assign tx_push    = bus.tx_valid & ~tx_full;
    assign tx_pop     = (state_q == S_TXWR) & ~tx_empty;
    assign rx_pop     = ~rx_empty & bus.rx_ready;
    assign rx_push    = (state_q == S_RXRD);
    // A full RX FIFO still accepts the byte when the host frees a slot now.
    assign rx_push_ok = rx_push & (~rx_full | rx_pop);
    assign rx_drop    = rx_push & ~rx_push_ok;

    assign bus.tx_ready  = ~tx_full;
    assign bus.rx_valid  = ~rx_empty;
    assign bus.rx_data   = rx_mem_q[rx_rd_ptr_q];
    assign bus.cfg_ready = cfg_take & ~reset;
    assign bus.overrun   = overrun_q;
    assign bus.irq       = ~rx_empty | (tx_empty & ~tx_busy_q);

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_POLL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = S_POLL;
        cfg_take = 1'b0;
        case (state_q)
            S_POLL: begin
                if (st[1]) begin
                    state_d = S_RXRD;
                end else if (bus.cfg_valid & tx_empty & tx_ok) begin
                    // Divisor only changes with the transmitter drained and idle.
                    state_d  = S_DIVL;
                    cfg_take = 1'b1;
                end else if (~tx_empty & tx_ok) begin
                    state_d = S_TXWR;
                end else begin
                    state_d = S_POLL;
                end
            end
            S_DIVL:  state_d = S_DIVH;
            default: state_d = S_POLL;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: register-port outputs, decoded from state only
    // ------------------------------------------------------------------
    always_comb begin
        bus.u_addr  = C_A_ST;
        bus.u_read  = 1'b0;
        bus.u_write = 1'b0;
        bus.u_wdata = 8'h00;
        case (state_q)
            S_POLL: begin
                bus.u_addr = C_A_ST;
                bus.u_read = 1'b1;
            end
            S_RXRD: begin
                bus.u_addr = C_A_RX;
                bus.u_read = 1'b1;
            end
            S_TXWR: begin
                bus.u_addr  = C_A_TX;
                bus.u_write = 1'b1;
                bus.u_wdata = tx_mem_q[tx_rd_ptr_q];
            end
            S_DIVL: begin
                bus.u_addr  = C_A_DL;
                bus.u_write = 1'b1;
                bus.u_wdata = div_q[7:0];
            end
            S_DIVH: begin
                bus.u_addr  = C_A_DH;
                bus.u_write = 1'b1;
                bus.u_wdata = {4'b0000, div_q[11:8]};
            end
            default: begin
                bus.u_addr = C_A_ST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_ptr_q] = bus.tx_data;
            tx_wr_ptr_d           = tx_wr_ptr_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
        end
        tx_count_d = tx_count_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end

    always_comb begin
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        if (rx_push_ok) begin
            rx_mem_d[rx_wr_ptr_q] = bus.u_rdata;
            rx_wr_ptr_d           = rx_wr_ptr_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
        end
        rx_count_d = rx_count_q + (AW+1)'(rx_push_ok) - (AW+1)'(rx_pop);
    end

    // ------------------------------------------------------------------
    // Transmitter busy, overrun and divisor holding registers
    // ------------------------------------------------------------------
    always_comb begin
        tx_busy_d = tx_busy_q;
        if (state_q == S_TXWR) begin
            tx_busy_d = 1'b1;
        end else if ((state_q == S_POLL) && st[0]) begin
            tx_busy_d = 1'b0;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        overrun_d = overrun_q;
        if (rx_drop) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end

        div_d = cfg_take ? bus.cfg_div : div_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            tx_busy_q   <= 1'b0;
            overrun_q   <= 1'b0;
            div_q       <= '0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
            tx_busy_q   <= tx_busy_d;
            overrun_q   <= overrun_d;
            div_q       <= div_d;
        end
    end

    // Storage needs no reset: every read is qualified by the counts.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

endmodule
`default_nettype wire
